led_refresh_scheduler: RTL and testbench

//  Sequences the serial LED-digit writer (8-bit DataIn, 4-bit AddressIn, WRITE pulse, CLEAR; 50 MHz SysClk, 1 MHz SCLK).

---
 rtl/led_refresh_scheduler_pkg.sv | 19 +
 rtl/led_refresh_scheduler_if.sv | 26 ++
 rtl/led_refresh_scheduler_rr_pick.sv | 27 ++
 rtl/led_refresh_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_led_refresh_scheduler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_refresh_scheduler_pkg.sv
// Shared constants, FSM state type and index helper for the LED refresh scheduler.
package led_pkg;
  localparam int LED_DIGITS = 8;
  localparam int LED_ADDR_W = 3;
  localparam int LED_DATA_W = 8;
  localparam int SCLK_DIV   = 50;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Digit index after i, wrapping 7 -> 0.
  function automatic logic [LED_ADDR_W-1:0] next_idx(input logic [LED_ADDR_W-1:0] i);
    return i + LED_ADDR_W'(1);
  endfunction
endpackage

// File: rtl/led_refresh_scheduler_if.sv
// Host-side write/clear strobes and writer-side outputs of the LED refresh scheduler.
interface led_refresh_scheduler_if;
  import led_pkg::*;

  // HostWrEn and HostClear are fire-and-forget strobes: there is no ready, every
  // asserted cycle is accepted. WRITEOut is a one-cycle pulse qualifying DataOut/AddressOut.
  logic                  HostWrEn;
  logic [LED_ADDR_W-1:0] HostAddr;
  logic [LED_DATA_W-1:0] HostData;
  logic                  HostClear;
  logic [LED_DATA_W-1:0] DataOut;
  logic [3:0]            AddressOut;
  logic                  WRITEOut;
  logic                  CLEAROut;
  logic                  Busy;

  modport master (
    output HostWrEn, HostAddr, HostData, HostClear,
    input  DataOut, AddressOut, WRITEOut, CLEAROut, Busy
  );

  modport slave (
    input  HostWrEn, HostAddr, HostData, HostClear,
    output DataOut, AddressOut, WRITEOut, CLEAROut, Busy
  );
endinterface

// File: rtl/led_refresh_scheduler_rr_pick.sv
// Round-robin picker: first dirty digit at or after ptr, wrapping modulo 8.
module led_rr_pick
  import led_pkg::*;
(
  input  logic [LED_DIGITS-1:0] dirty,
  input  logic [LED_ADDR_W-1:0] ptr,
  output logic [LED_ADDR_W-1:0] idx,
  output logic                  valid
);

  logic [LED_ADDR_W-1:0] cand;

  // Scan from the farthest offset down so the nearest dirty entry is written last.
  always_comb begin
    idx   = ptr;
    valid = 1'b0;
    cand  = ptr;
    for (int i = LED_DIGITS - 1; i >= 0; i--) begin
      cand = ptr + LED_ADDR_W'(i);
      if (dirty[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_refresh_scheduler.sv
// Shadows 8 LED digits and replays dirty ones to the serial writer, paced by a cycle
// budget, with writer CLEAR sequencing and an optional periodic full refresh.
module led_refresh_scheduler
  import led_pkg::*;
#(
  parameter int TX_CYCLES      = 416,
  parameter int CLR_CYCLES     = 8,
  parameter int REFRESH_CYCLES = 5000000
) (
  input  logic                    SysClk,
  input  logic                    SysRst,
  led_refresh_scheduler_if.slave  bus,
  output state_t                  dbg_state,
  output logic [LED_DIGITS-1:0]   dbg_dirty
);

  localparam int CNT_MAX = (TX_CYCLES > CLR_CYCLES) ? TX_CYCLES : CLR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t                state_q, state_d;
  logic [LED_DATA_W-1:0] shadow_q [LED_DIGITS];
  logic [LED_DATA_W-1:0] shadow_d [LED_DIGITS];
  logic [LED_DIGITS-1:0] dirty_q, dirty_d;
  logic                  clr_pend_q, clr_pend_d;
  logic [LED_ADDR_W-1:0] ptr_q, ptr_d;
  logic [LED_ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LED_DATA_W-1:0] data_out_q, data_out_d;
  logic [3:0]            addr_out_q, addr_out_d;
  logic                  write_q, write_d;
  logic                  clear_q, clear_d;
  logic                  busy_q, busy_d;

  logic                  refresh_tick;
  logic                  decide;
  logic                  take_clear;
  logic [LED_ADDR_W-1:0] pick_ptr;
  logic [LED_ADDR_W-1:0] pick_idx;
  logic                  pick_valid;

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          at_wrap;

      assign at_wrap      = (rcnt_q == RW'(REFRESH_CYCLES - 1));
      assign refresh_tick = at_wrap;

      always_comb begin
        rcnt_d = at_wrap ? '0 : rcnt_q + RW'(1);
      end

      always_ff @(posedge SysClk or negedge SysRst) begin
        if (!SysRst) rcnt_q <= '0;
        else         rcnt_q <= rcnt_d;
      end
    end else begin : g_no_refresh
      assign refresh_tick = 1'b0;
    end
  endgenerate

  // Leaving WAIT makes the IDLE decision directly, using the pointer it is about to store.
  assign pick_ptr = (state_q == WAIT) ? next_idx(idx_q) : ptr_q;

  led_rr_pick u_pick (
    .dirty (dirty_q),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    dirty_d    = dirty_q;
    clr_pend_d = clr_pend_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    addr_out_d = addr_out_q;
    write_d    = 1'b0;
    clear_d    = clear_q;
    busy_d     = busy_q;
    decide     = 1'b0;
    take_clear = 1'b0;

    case (state_q)
      IDLE: decide = 1'b1;
      ISSUE: begin
        dirty_d[idx_q] = 1'b0;
        cnt_d          = CNT_W'(TX_CYCLES - 1);
        state_d        = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ptr_d   = next_idx(idx_q);
          busy_d  = 1'b0;
          state_d = IDLE;
          decide  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          clear_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (decide) begin
      if (clr_pend_q) begin
        take_clear = 1'b1;
        shadow_d   = '{default: '0};
        dirty_d    = '0;
        clr_pend_d = 1'b0;
        clear_d    = 1'b1;
        busy_d     = 1'b1;
        cnt_d      = CNT_W'(CLR_CYCLES - 1);
        state_d    = CLEAR;
      end else if (pick_valid) begin
        idx_d      = pick_idx;
        data_out_d = shadow_q[pick_idx];
        addr_out_d = {1'b0, pick_idx};
        write_d    = 1'b1;
        busy_d     = 1'b1;
        state_d    = ISSUE;
      end
    end

    // A clear request arriving on the edge that starts a clear is satisfied by it.
    if (bus.HostClear && !take_clear) clr_pend_d = 1'b1;
    // Ordering matters: zeroing/issue first, then refresh, then the host write wins.
    if (refresh_tick) dirty_d = '1;
    if (bus.HostWrEn) begin
      shadow_d[bus.HostAddr] = bus.HostData;
      dirty_d[bus.HostAddr]  = 1'b1;
    end
  end

  always_ff @(posedge SysClk or negedge SysRst) begin
    if (!SysRst) begin
      state_q    <= IDLE;
      shadow_q   <= '{default: '0};
      dirty_q    <= '0;
      clr_pend_q <= 1'b0;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      addr_out_q <= '0;
      write_q    <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      dirty_q    <= dirty_d;
      clr_pend_q <= clr_pend_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      addr_out_q <= addr_out_d;
      write_q    <= write_d;
      clear_q    <= clear_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.DataOut    = data_out_q;
  assign bus.AddressOut = addr_out_q;
  assign bus.WRITEOut   = write_q;
  assign bus.CLEAROut   = clear_q;
  assign bus.Busy       = busy_q;
  assign dbg_state      = state_q;
  assign dbg_dirty      = dirty_q;

endmodule

// File: tb/tb_led_refresh_scheduler.sv
// Scoreboard bench: dut0 without refresh for write/clear sequencing, dut1 with a short refresh period.
module tb_led_refresh_scheduler;
  import led_pkg::*;

  // ---------------- clock / reset ----------------
  logic SysClk = 1'b0;
  logic rst0_n;
  logic rst1_n;
  always #10 SysClk = ~SysClk;

  int unsigned cyc = 0;
  always @(posedge SysClk) cyc <= cyc + 1;

  led_refresh_scheduler_if bus0 ();
  led_refresh_scheduler_if bus1 ();
  state_t     st0, st1;
  logic [7:0] dirty0, dirty1;

  led_refresh_scheduler #(.TX_CYCLES(416), .CLR_CYCLES(8), .REFRESH_CYCLES(0)) dut0 (
    .SysClk(SysClk), .SysRst(rst0_n), .bus(bus0), .dbg_state(st0), .dbg_dirty(dirty0)
  );

  led_refresh_scheduler #(.TX_CYCLES(100), .CLR_CYCLES(8), .REFRESH_CYCLES(2000)) dut1 (
    .SysClk(SysClk), .SysRst(rst1_n), .bus(bus1), .dbg_state(st1), .dbg_dirty(dirty1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp0_q[$];
  logic [11:0] exp1_q[$];
  int          clr0_q[$];
  int unsigned wr0_cyc[$];
  int unsigned wr1_cyc[$];
  int          busy0_lens[$];
  int          busy0_run = 0;
  int          clr0_run  = 0;
  int unsigned clr0_start = 0;
  logic [11:0] e0, e1;
  int          c0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp_v);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge SysClk) begin
    if (bus0.WRITEOut === 1'b1) begin
      wr0_cyc.push_back(cyc);
      if (exp0_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL write0_unexpected: got %0h want none", {bus0.AddressOut, bus0.DataOut});
      end else begin
        e0 = exp0_q.pop_front();
        check("write0", {20'h0, bus0.AddressOut, bus0.DataOut}, {20'h0, e0});
      end
    end
    if (bus0.CLEAROut === 1'b1) begin
      if (clr0_run == 0) clr0_start = cyc;
      clr0_run++;
    end else if (clr0_run != 0) begin
      if (clr0_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL clear0_unexpected: got len %0d want none", clr0_run);
      end else begin
        c0 = clr0_q.pop_front();
        check("clear0_len", clr0_run, c0);
      end
      clr0_run = 0;
    end
    if (bus0.Busy === 1'b1) begin
      busy0_run++;
    end else if (busy0_run != 0) begin
      busy0_lens.push_back(busy0_run);
      busy0_run = 0;
    end
  end

  always @(negedge SysClk) begin
    if (bus1.WRITEOut === 1'b1) begin
      wr1_cyc.push_back(cyc);
      if (exp1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL write1_unexpected: got %0h want none", {bus1.AddressOut, bus1.DataOut});
      end else begin
        e1 = exp1_q.pop_front();
        check("write1", {20'h0, bus1.AddressOut, bus1.DataOut}, {20'h0, e1});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wr0(input logic [2:0] a, input logic [7:0] d);
    bus0.HostWrEn = 1'b1; bus0.HostAddr = a; bus0.HostData = d;
    @(negedge SysClk);
    bus0.HostWrEn = 1'b0;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [7:0] d);
    bus1.HostWrEn = 1'b1; bus1.HostAddr = a; bus1.HostData = d;
    @(negedge SysClk);
    bus1.HostWrEn = 1'b0;
  endtask

  task automatic wait_q0_empty(input int budget, input string name);
    int n = 0;
    while (exp0_q.size() != 0 && n < budget) begin @(negedge SysClk); n++; end
    check(name, exp0_q.size(), 0);
  endtask

  task automatic wait_q1_empty(input int budget, input string name);
    int n = 0;
    while (exp1_q.size() != 0 && n < budget) begin @(negedge SysClk); n++; end
    check(name, exp1_q.size(), 0);
  endtask

  task automatic wait_quiet0(input int budget, input string name);
    int n = 0;
    logic ok;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge SysClk); n++;
      ok = (exp0_q.size() == 0) && (clr0_q.size() == 0) && (st0 == IDLE) && (bus0.Busy == 1'b0);
    end
    check(name, ok, 1);
    @(negedge SysClk);
  endtask

  int unsigned w, a;
  int          n;
  logic [7:0]  pre [8];

  // ---------------- directed sequence ----------------
  initial begin
    pre = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    bus0.HostWrEn = 1'b0; bus0.HostAddr = '0; bus0.HostData = '0; bus0.HostClear = 1'b0;
    bus1.HostWrEn = 1'b0; bus1.HostAddr = '0; bus1.HostData = '0; bus1.HostClear = 1'b0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(negedge SysClk);

    check("rst_dataout",  bus0.DataOut, 0);
    check("rst_addrout",  bus0.AddressOut, 0);
    check("rst_writeout", bus0.WRITEOut, 0);
    check("rst_clearout", bus0.CLEAROut, 0);
    check("rst_busy",     bus0.Busy, 0);
    check("rst_state",    st0, IDLE);
    check("rst_dirty",    dirty0, 0);
    rst0_n = 1'b1;
    @(negedge SysClk);

    // 1: single write, latency 2, busy 417
    w = cyc;
    exp0_q.push_back({4'h3, 8'hA5});
    wr0(3'd3, 8'hA5);
    wait_q0_empty(20, "t1_write_timeout");
    check("t1_latency", wr0_cyc[wr0_cyc.size()-1] - w, 2);
    wait_quiet0(600, "t1_quiet");
    check("t1_busy_len", busy0_lens[busy0_lens.size()-1], 417);

    // 2: three back-to-back writes, order 0,5,7, spacing 417
    exp0_q.push_back({4'h0, 8'h3F});
    exp0_q.push_back({4'h5, 8'h6D});
    exp0_q.push_back({4'h7, 8'h07});
    wr0(3'd0, 8'h3F);
    wr0(3'd5, 8'h6D);
    wr0(3'd7, 8'h07);
    wait_quiet0(1500, "t2_quiet");
    n = wr0_cyc.size();
    check("t2_spacing_a", wr0_cyc[n-2] - wr0_cyc[n-3], 417);
    check("t2_spacing_b", wr0_cyc[n-1] - wr0_cyc[n-2], 417);
    check("t2_busy_len", busy0_lens[busy0_lens.size()-1], 1251);

    // 3: rewrite of the in-flight digit during WAIT is not lost
    exp0_q.push_back({4'h2, 8'h77});
    wr0(3'd2, 8'h77);
    wait_q0_empty(20, "t3_first_timeout");
    repeat (10) @(negedge SysClk);
    exp0_q.push_back({4'h2, 8'h3C});
    wr0(3'd2, 8'h3C);
    wait_quiet0(1000, "t3_quiet");
    n = wr0_cyc.size();
    check("t3_spacing", wr0_cyc[n-1] - wr0_cyc[n-2], 417);
    check("t3_busy_len", busy0_lens[busy0_lens.size()-1], 834);

    // 4: clear mid-WAIT lets the transfer finish, then CLEAR for 8 cycles
    exp0_q.push_back({4'h1, 8'h5A});
    clr0_q.push_back(8);
    wr0(3'd1, 8'h5A);
    wait_q0_empty(20, "t4_write_timeout");
    repeat (20) @(negedge SysClk);
    bus0.HostClear = 1'b1;
    @(negedge SysClk);
    bus0.HostClear = 1'b0;
    wait_quiet0(600, "t4_quiet");
    check("t4_clear_after_write", clr0_start - wr0_cyc[wr0_cyc.size()-1], 417);
    check("t4_busy_len", busy0_lens[busy0_lens.size()-1], 425);
    check("t4_dirty_zero", dirty0, 0);
    repeat (40) @(negedge SysClk);
    check("t4_write_count", wr0_cyc.size(), 7);

    // 5: host write on the IDLE->CLEAR edge survives and is written after CLEAR
    a = cyc;
    clr0_q.push_back(8);
    bus0.HostClear = 1'b1;
    @(negedge SysClk);
    bus0.HostClear = 1'b0;
    exp0_q.push_back({4'h4, 8'h11});
    wr0(3'd4, 8'h11);
    wait_quiet0(600, "t5_quiet");
    check("t5_clear_start", clr0_start - a, 2);
    check("t5_write_after_clear", wr0_cyc[wr0_cyc.size()-1] - clr0_start, 9);
    n = busy0_lens.size();
    check("t5_busy_clear", busy0_lens[n-2], 8);
    check("t5_busy_write", busy0_lens[n-1], 417);
    check("t5_dirty_zero", dirty0, 0);

    // 6: periodic refresh on dut1, then async reset mid-WAIT
    rst1_n = 1'b1;
    @(negedge SysClk);
    for (int i = 0; i < 8; i++) begin
      exp1_q.push_back({4'(i), pre[i]});
      wr1(3'(i), pre[i]);
    end
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++)
        exp1_q.push_back({4'(i), pre[i]});
    exp1_q.push_back({4'h0, pre[0]});
    wait_q1_empty(7000, "t6_refresh_timeout");
    check("t6_write_count", wr1_cyc.size(), 25);
    if (wr1_cyc.size() >= 25) begin
      check("t6_period_a", wr1_cyc[16] - wr1_cyc[8], 2000);
      check("t6_period_b", wr1_cyc[24] - wr1_cyc[16], 2000);
      check("t6_burst_spacing", wr1_cyc[9] - wr1_cyc[8], 101);
      check("t6_burst_span", wr1_cyc[15] - wr1_cyc[8], 707);
    end
    repeat (10) @(negedge SysClk);
    check("t6_in_wait", st1, WAIT);
    check("t6_busy_before_rst", bus1.Busy, 1);
    @(posedge SysClk);
    #5;
    rst1_n = 1'b0;
    #1;
    check("t6_rst_dataout",  bus1.DataOut, 0);
    check("t6_rst_addrout",  bus1.AddressOut, 0);
    check("t6_rst_writeout", bus1.WRITEOut, 0);
    check("t6_rst_clearout", bus1.CLEAROut, 0);
    check("t6_rst_busy",     bus1.Busy, 0);
    check("t6_rst_state",    st1, IDLE);
    check("t6_rst_dirty",    dirty1, 0);
    repeat (5) @(negedge SysClk);
    check("t6_write_count_after_rst", wr1_cyc.size(), 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
